alu_issue_arbiter: RTL
======================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares one combinational ALU among NREQ issue slots of the VLIW execute stage.
//  Round-robin arbitration over valid/ready request channels; drives the ALU's a/b/operationSelect.
//  Captures q in a 1-entry result register with the winner's slot ID, under valid/ready backpressure.
//  Sits between the issue slots and the shared ALU; results return to writeback.
// PARAMETERS
//  OPERANDSIZE  64  operand/result width, passed through to the ALU
//  NREQ         4   number of requesting issue slots (>=1)
//  IDW          $clog2(NREQ)>0 ? $clog2(NREQ) : 1   slot-ID width (derived, localparam)
// PORTS
//  clk         in   1                  clock; all state on rising edge
//  rst         in   1                  reset, asynchronous, active-high
//  req_valid   in   NREQ               slot i presents an operation
//  req_ready   out  NREQ               slot i's operation accepted this cycle
//  req_a       in   NREQ*OPERANDSIZE   packed operand a, slot i at [i*OPERANDSIZE +: OPERANDSIZE]
//  req_b       in   NREQ*OPERANDSIZE   packed operand b, same packing
//  req_op      in   NREQ*12            packed operationSelect, slot i at [i*12 +: 12]
//  alu_a       out  OPERANDSIZE        to ALU a
//  alu_b       out  OPERANDSIZE        to ALU b
//  alu_op      out  12                 to ALU operationSelect
//  alu_q       in   OPERANDSIZE        from ALU q (combinational)
//  res_valid   out  1                  result register holds a result
//  res_ready   in   1                  consumer takes result this cycle
//  res_q       out  OPERANDSIZE        registered result
//  res_id      out  IDW                slot that issued the result
// BEHAVIOUR
//  Reset (async assert, sync-safe release): res_valid=0, res_q=0, res_id=0, rr pointer=0.
//  - req_ready=0 while rst is high.
//  accept_ok = !res_valid || res_ready (slot empty, or draining this cycle).
//  Grant: first i with req_valid[i], searching pointer, pointer+1 .. mod NREQ. Combinational; one-hot.
//  - req_ready[i] = grant[i] && accept_ok. All others 0; none asserted if no req_valid.
//  - alu_a/alu_b/alu_op mux from the granted slot; drive all zeros when no grant.
//  Accept (req_valid[i] && req_ready[i]) at edge: res_q<=alu_q, res_id<=i, res_valid<=1,
//  - pointer <= (i+1) mod NREQ. No accept: pointer unchanged.
//  Latency: accept in cycle N -> res_valid/res_q visible cycle N+1. Throughput: 1 op/cycle.
//  Drain without accept: res_valid<=0. Drain + accept in same cycle: res_valid stays 1 with new data.
//  res_valid && !res_ready: res_q/res_id held stable; all req_ready=0 (full stall).
//  Requesters hold a/b/op stable while req_valid && !req_ready; they may not withdraw valid.
//  Arithmetic: none here; wrap/overflow is the ALU's. Unknown op codes pass through; ALU returns 0.
//  Reset mid-operation: held/in-flight result discarded, no replay; pointer returns to 0.
//  Fairness: any continuously-valid slot is granted within NREQ accepts.
//  NREQ=1: pointer degenerates to constant 0; behaves as a 1-deep pipeline register.
// STRUCTURE
//  Package alu_pkg: ALU_OP_ADD=12'd0, ALU_OP_SUB=12'd1, ALU_OPSEL_W=12 (replaces local `defines).
//  - Shares op encodings with the ALU itself.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr; output grant[N] one-hot, grant_idx.
//  - Purely combinational; pointer register lives in the parent.
//  Top: rr_arbiter instance, operand mux, result register, pointer register.
//  - ALU instantiated by the integrator, not inside this block.
// TESTING
//  1 Single issue: slot0 op=0 a=5 b=7, res_ready=1 -> req_ready[0]=1 same cycle.
//    - Next cycle res_valid=1, res_q=12, res_id=0.
//  2 Contention: all 4 slots valid every cycle, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
//    - res_id sequence matches; no bubbles.
//  3 Backpressure: res_valid=1, res_ready=0 for 3 cycles -> all req_ready=0, res_q/res_id unchanged.
//    - Raising res_ready drains and accepts in the same cycle.
//  4 Wrap/passthrough: ADD a=64'hFFFF_FFFF_FFFF_FFFF b=1 -> res_q=0.
//    - op=12'd5 -> res_q=0, res_valid=1.
//  5 Reset mid-op: assert rst while res_valid=1 -> res_valid=0 immediately, no clock edge needed.
//    - After release, slots 3 and 1 valid -> slot 1 granted first (pointer=0).
//  6 Pointer skip: only slot 2 valid after grant to slot 0 -> slot 2 granted; pointer becomes 3.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: operation-select encodings and widths shared between the ALU and
// the blocks that feed it.
package alu_pkg;

  localparam int unsigned ALU_OPSEL_W = 12;

  localparam logic [ALU_OPSEL_W-1:0] ALU_OP_ADD = 12'd0;
  localparam logic [ALU_OPSEL_W-1:0] ALU_OP_SUB = 12'd1;

endpackage : alu_pkg

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req       in   N    request vector
//   ptr       in   IW   highest-priority index (owned by the parent)
//   grant     out  N    one-hot grant, all zeros when no request
//   grant_idx out  IW   index of the granted request (0 when no grant)
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int unsigned idx;
  logic        found;

  // Scan ptr, ptr+1, ... (mod N); the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[IW'(idx)]) begin
        found            = 1'b1;
        grant[IW'(idx)]  = 1'b1;
        grant_idx        = IW'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one combinational ALU among NREQ issue slots.
// Round-robin grant over valid/ready request channels, operand mux to the ALU,
// and a 1-entry result register tagged with the issuing slot.
//   clk, rst              clock, async active-high reset
//   req_valid/req_ready   per-slot request handshake
//   req_a/req_b/req_op    packed per-slot operands and operation select
//   alu_a/alu_b/alu_op    to the shared ALU (zeros when nothing granted)
//   alu_q                 combinational ALU result
//   res_valid/res_ready   result handshake toward writeback
//   res_q/res_id          registered result and issuing slot
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned OPERANDSIZE = 64,
  parameter  int unsigned NREQ        = 4,
  localparam int unsigned IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*OPERANDSIZE-1:0] req_a,
  input  logic [NREQ*OPERANDSIZE-1:0] req_b,
  input  logic [NREQ*ALU_OPSEL_W-1:0] req_op,
  output logic [OPERANDSIZE-1:0]      alu_a,
  output logic [OPERANDSIZE-1:0]      alu_b,
  output logic [ALU_OPSEL_W-1:0]      alu_op,
  input  logic [OPERANDSIZE-1:0]      alu_q,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [OPERANDSIZE-1:0]      res_q,
  output logic [IDW-1:0]              res_id
);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            accept_ok;
  logic            accept;
  logic            last_slot;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Result slot can take a new op when empty or being drained this cycle.
  assign accept_ok = !res_valid || res_ready;
  assign req_ready = grant & {NREQ{accept_ok && !rst}};
  assign accept    = |req_ready;
  assign last_slot = (32'(grant_idx) == NREQ - 1);

  // Operand mux from the granted slot; grant is one-hot so AND-OR is exact.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_a  = req_a[i*OPERANDSIZE +: OPERANDSIZE];
        alu_b  = req_b[i*OPERANDSIZE +: OPERANDSIZE];
        alu_op = req_op[i*ALU_OPSEL_W +: ALU_OPSEL_W];
      end
    end
  end

  // Result register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_q     <= '0;
      res_id    <= '0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        res_valid <= 1'b1;
        res_q     <= alu_q;
        res_id    <= grant_idx;
        ptr       <= last_slot ? '0 : grant_idx + IDW'(1);
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule : alu_issue_arbiter
